// File: rtl/board_move_scheduler.sv
// ---------------------------------------------------------------------------
// board_move_scheduler
//   Arbitrates red / blue player move requests for the shared board BRAM port
//   and the tile drawer. A granted move erases the player's old cell, paints
//   the new cell, reads both cells back, draws each one (waiting for the
//   drawer after each draw) and then acknowledges the requester. A move onto
//   the other player's cell is refused with ack + reject and touches nothing.
//
// Ports
//   clock, resetn            system clock, synchronous active-low reset
//   red_req/red_x/red_y      red request (held until red_ack) and target cell
//   red_ack                  one-cycle pulse, red move finished or refused
//   blue_req/blue_x/blue_y   blue request and target cell
//   blue_ack                 one-cycle pulse, blue move finished or refused
//   reject                   pulses with the ack when the move was refused
//   mem_addr/mem_wdata       BRAM address {0,y,x} and write colour
//   mem_wren/mem_rden        BRAM write / read enable (read latency 1)
//   mem_rdata                BRAM read data
//   draw_start               one-cycle pulse, start a tile draw
//   draw_x/draw_y            cell being drawn, held until the drawer is done
//   draw_colour              colour captured from the BRAM read-back
//   draw_done                drawer finished, only looked at while waiting
//   busy                     high whenever a move is in progress
// ---------------------------------------------------------------------------
module board_move_scheduler #(
    parameter logic [3:0] RED_X0      = 4'd1,
    parameter logic [3:0] RED_Y0      = 4'd1,
    parameter logic [3:0] BLUE_X0     = 4'd4,
    parameter logic [3:0] BLUE_Y0     = 4'd3,
    parameter logic [2:0] RED_COLOUR  = 3'b100,
    parameter logic [2:0] BLUE_COLOUR = 3'b001,
    parameter logic [2:0] BG_COLOUR   = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       red_req,
    input  logic [3:0] red_x,
    input  logic [3:0] red_y,
    output logic       red_ack,
    input  logic       blue_req,
    input  logic [3:0] blue_x,
    input  logic [3:0] blue_y,
    output logic       blue_ack,
    output logic       reject,
    output logic [8:0] mem_addr,
    output logic [2:0] mem_wdata,
    output logic       mem_wren,
    output logic       mem_rden,
    input  logic [2:0] mem_rdata,
    output logic       draw_start,
    output logic [3:0] draw_x,
    output logic [3:0] draw_y,
    output logic [2:0] draw_colour,
    input  logic       draw_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, GRANT, ERASE, PAINT,
        RD_OLD, CAP_OLD, DRAW_OLD, WAIT_OLD,
        RD_NEW, CAP_NEW, DRAW_NEW, WAIT_NEW,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic       last_blue_q, last_blue_d;     // 1: last tie went to blue
    logic       sel_blue_q, sel_blue_d;       // player owning the current move
    logic       reject_q, reject_d;
    logic [3:0] old_x_q, old_x_d, old_y_q, old_y_d;
    logic [3:0] new_x_q, new_x_d, new_y_q, new_y_d;
    logic [2:0] colour_q, colour_d;
    logic [2:0] draw_colour_q, draw_colour_d;
    logic [3:0] red_x_q, red_x_d, red_y_q, red_y_d;
    logic [3:0] blue_x_q, blue_x_d, blue_y_q, blue_y_d;

    logic tie;
    logic pick_blue;

    function automatic logic [8:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        return {1'b0, y, x};
    endfunction

    assign tie = red_req && blue_req;
    // On a tie the player who did not win the previous tie goes first;
    // otherwise whoever is asking.
    assign pick_blue = tie ? !last_blue_q : !red_req;

    assign draw_colour = draw_colour_q;

    always_comb begin
        state_d       = state_q;
        last_blue_d   = last_blue_q;
        sel_blue_d    = sel_blue_q;
        reject_d      = reject_q;
        old_x_d       = old_x_q;
        old_y_d       = old_y_q;
        new_x_d       = new_x_q;
        new_y_d       = new_y_q;
        colour_d      = colour_q;
        draw_colour_d = draw_colour_q;
        red_x_d       = red_x_q;
        red_y_d       = red_y_q;
        blue_x_d      = blue_x_q;
        blue_y_d      = blue_y_q;

        red_ack    = 1'b0;
        blue_ack   = 1'b0;
        reject     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wren   = 1'b0;
        mem_rden   = 1'b0;
        draw_start = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (red_req || blue_req) state_d = GRANT;
            end
            GRANT: begin
                if (!(red_req || blue_req)) begin
                    state_d = IDLE;
                end else begin
                    sel_blue_d = pick_blue;
                    if (tie) last_blue_d = pick_blue;
                    if (pick_blue) begin
                        new_x_d  = blue_x;
                        new_y_d  = blue_y;
                        old_x_d  = blue_x_q;
                        old_y_d  = blue_y_q;
                        colour_d = BLUE_COLOUR;
                        reject_d = (blue_x == red_x_q) && (blue_y == red_y_q);
                    end else begin
                        new_x_d  = red_x;
                        new_y_d  = red_y;
                        old_x_d  = red_x_q;
                        old_y_d  = red_y_q;
                        colour_d = RED_COLOUR;
                        reject_d = (red_x == blue_x_q) && (red_y == blue_y_q);
                    end
                    state_d = reject_d ? DONE : ERASE;
                end
            end
            ERASE: begin
                mem_wren  = 1'b1;
                mem_addr  = cell_addr(old_x_q, old_y_q);
                mem_wdata = BG_COLOUR;
                state_d   = PAINT;
            end
            PAINT: begin
                mem_wren  = 1'b1;
                mem_addr  = cell_addr(new_x_q, new_y_q);
                mem_wdata = colour_q;
                state_d   = RD_OLD;
            end
            RD_OLD: begin
                mem_rden = 1'b1;
                mem_addr = cell_addr(old_x_q, old_y_q);
                state_d  = CAP_OLD;
            end
            CAP_OLD: begin
                draw_colour_d = mem_rdata;
                state_d       = DRAW_OLD;
            end
            DRAW_OLD: begin
                draw_start = 1'b1;
                draw_x     = old_x_q;
                draw_y     = old_y_q;
                state_d    = WAIT_OLD;
            end
            WAIT_OLD: begin
                draw_x = old_x_q;
                draw_y = old_y_q;
                if (draw_done) state_d = RD_NEW;
            end
            RD_NEW: begin
                mem_rden = 1'b1;
                mem_addr = cell_addr(new_x_q, new_y_q);
                state_d  = CAP_NEW;
            end
            CAP_NEW: begin
                draw_colour_d = mem_rdata;
                state_d       = DRAW_NEW;
            end
            DRAW_NEW: begin
                draw_start = 1'b1;
                draw_x     = new_x_q;
                draw_y     = new_y_q;
                state_d    = WAIT_NEW;
            end
            WAIT_NEW: begin
                draw_x = new_x_q;
                draw_y = new_y_q;
                if (draw_done) state_d = DONE;
            end
            DONE: begin
                red_ack  = !sel_blue_q;
                blue_ack = sel_blue_q;
                reject   = reject_q;
                if (!reject_q) begin
                    if (sel_blue_q) begin
                        blue_x_d = new_x_q;
                        blue_y_d = new_y_q;
                    end else begin
                        red_x_d = new_x_q;
                        red_y_d = new_y_q;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, positions and the visible draw colour are reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            last_blue_q   <= 1'b1;
            draw_colour_q <= '0;
            red_x_q       <= RED_X0;
            red_y_q       <= RED_Y0;
            blue_x_q      <= BLUE_X0;
            blue_y_q      <= BLUE_Y0;
        end else begin
            state_q       <= state_d;
            last_blue_q   <= last_blue_d;
            draw_colour_q <= draw_colour_d;
            red_x_q       <= red_x_d;
            red_y_q       <= red_y_d;
            blue_x_q      <= blue_x_d;
            blue_y_q      <= blue_y_d;
        end
    end

    // Per-move latches; only consulted after GRANT has loaded them.
    always_ff @(posedge clock) begin
        sel_blue_q <= sel_blue_d;
        reject_q   <= reject_d;
        old_x_q    <= old_x_d;
        old_y_q    <= old_y_d;
        new_x_q    <= new_x_d;
        new_y_q    <= new_y_d;
        colour_q   <= colour_d;
    end

endmodule
